// File: rtl/result_uart_tx.sv
// Sends a calculator result as an ASCII hex line ("HHHH[!]\r\n") over UART 8N1.
// Define OP_TAG_EN to prefix each line with the operation tag ("FA:", "FM:", "XA:" or "XM:").
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] result,
    input  logic        overflow,
    input  logic [1:0]  op,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef OP_TAG_EN
    localparam int PREFIX = 3;
`else
    localparam int PREFIX = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [3:0]        r_char_idx;
    logic [7:0]        r_shift;
    logic [15:0]       r_result;
    logic              r_overflow;
    logic [1:0]        r_op;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic [7:0]        w_char;
    logic [3:0]        w_rel;
    logic [3:0]        w_last_idx;
    logic              w_accept;
    logic              w_baud_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_accept   = start && !r_busy;
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_last_idx = 4'(PREFIX) + (r_overflow ? 4'd6 : 4'd5);

    // Character currently being sent, selected from the captured values by index.
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    always_comb begin
        w_rel  = r_char_idx - 4'(PREFIX);
        w_char = 8'h0A;
        case (w_rel)
            4'd0:    w_char = hex_ascii(r_result[15:12]);
            4'd1:    w_char = hex_ascii(r_result[11:8]);
            4'd2:    w_char = hex_ascii(r_result[7:4]);
            4'd3:    w_char = hex_ascii(r_result[3:0]);
            4'd4:    w_char = r_overflow ? 8'h21 : 8'h0D;
            4'd5:    w_char = r_overflow ? 8'h0D : 8'h0A;
            default: w_char = 8'h0A;
        endcase
`ifdef OP_TAG_EN
        if (r_char_idx == 4'd0)
            w_char = r_op[1] ? 8'h58 : 8'h46;
        else if (r_char_idx == 4'd1)
            w_char = r_op[0] ? 8'h4D : 8'h41;
        else if (r_char_idx == 4'd2)
            w_char = 8'h3A;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_char_idx <= '0;
            r_shift    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_op       <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FINISH: begin
                    // A start seen in the done cycle is accepted, giving one idle cycle between lines.
                    if (w_accept) begin
                        r_result   <= result;
                        r_overflow <= overflow;
                        r_op       <= op;
                        r_char_idx <= '0;
                        r_baud     <= '0;
                        r_bit      <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end else begin
                        r_char_idx <= '0;
                        r_tx       <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_char[0];
                        r_shift <= {1'b0, w_char[7:1]};
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_char_idx == w_last_idx) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_char_idx <= r_char_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
